// File: rtl/soc_bus_hub.sv
`default_nettype none
// ============================================================================
// Module  : soc_bus_hub
// Brief   : Single-master memory-bus hub with address-window decode, response
//           capture, timeout watchdog and debug write trace.
// Revision: 1.0
// ============================================================================
module soc_bus_hub #(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 28,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req_valid,
    output logic                         m_req_ready,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic                         m_rsp_valid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_req_valid,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]        s_rsp_valid,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         dbg_we,
    output logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data,
    output logic [15:0]                  err_count
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_wait = 2'd1;
    localparam logic [1:0]  c_st_resp = 2'd2;
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [SEL_W-1:0]      r_idx;
    logic [15:0]           r_cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic                  r_dbg_we;
    logic [15:0]           r_err_count;

    logic [SEL_W-1:0]      w_idx;
    logic                  w_idx_ok;
    logic                  w_accept;
    logic                  w_in_wait;
    logic                  w_sel_rsp;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic [NUM_SLAVES-1:0] w_s_req;
    logic                  w_timeout;
    logic                  w_err_evt;

    assign w_idx     = m_addr[SEL_LSB +: SEL_W];
    assign w_idx_ok  = (32'(w_idx) < 32'(NUM_SLAVES));
    assign w_accept  = m_req_valid && (r_state == c_st_idle);
    assign w_in_wait = (r_state == c_st_wait);
    assign w_timeout = (r_cnt >= c_cnt_last);

    // Only the latched slave's response and data are visible to the hub.
    always_comb begin
        w_sel_rsp   = 1'b0;
        w_sel_rdata = '0;
        w_s_req     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_sel_rsp   = s_rsp_valid[i];
                w_sel_rdata = s_rdata[i*DATA_W +: DATA_W];
                w_s_req[i]  = w_in_wait;
            end
        end
    end

    // A response in the expiry cycle wins over the timeout.
    assign w_err_evt = (w_accept && !w_idx_ok) || (w_in_wait && !w_sel_rsp && w_timeout);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_idx_ok ? c_st_wait : c_st_resp;
                end
            end
            c_st_wait: begin
                if (w_sel_rsp || w_timeout) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_dbg_we    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_dbg_we <= w_accept && m_we;
            if (w_accept) begin
                r_we    <= m_we;
                r_addr  <= m_addr;
                r_wdata <= m_wdata;
                r_idx   <= w_idx;
                r_cnt   <= '0;
                if (!w_idx_ok) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (w_in_wait) begin
                r_cnt <= r_cnt + 16'd1;
                if (w_sel_rsp) begin
                    r_rdata <= r_we ? '0 : w_sel_rdata;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (w_err_evt && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign m_req_ready = (r_state == c_st_idle);
    assign m_rsp_valid = (r_state == c_st_resp);
    assign m_rdata     = r_rdata;
    assign m_err       = r_err;
    assign s_req_valid = w_s_req;
    assign s_we        = r_we;
    assign s_addr      = r_addr;
    assign s_wdata     = r_wdata;
    assign dbg_we      = r_dbg_we;
    assign dbg_addr    = r_addr;
    assign dbg_data    = r_wdata;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire
